acc_cpu: RTL and testbench

Parametrised accumulator processor: the next generation of the team's 8-bit switch/LED processor, generalised in data width, memory depth and arithmetic mode. It executes a single-accumulator instruction set from a unified internal memory loaded through a program port, with a synchronised `enter` handshake for operator input. It is the top-level core that the board wrapper connects to switches, push-buttons and LEDs.

---
 rtl/acc_cpu_pkg.sv | 47 ++++
 rtl/acc_cpu_enter_sync.sv | 25 ++
 rtl/acc_cpu.sv | 182 ++++++++++++++++++
 tb/tb_acc_cpu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and control-word layout for the acc_cpu core.
package acc_cpu_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OPC_W-1:0] OP_IN    = 3'b100;
  localparam logic [OPC_W-1:0] OP_OUT   = 3'b101;
  localparam logic [OPC_W-1:0] OP_JZ    = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT_IN = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACC_MEM = 2'd0,
    ACC_ADD = 2'd1,
    ACC_SUB = 2'd2,
    ACC_IN  = 2'd3
  } acc_src_t;

  // One-cycle control word produced by the FSM output decoder.
  typedef struct packed {
    logic     clr;
    logic     fetch;
    logic     pc_jmp;
    logic     acc_we;
    acc_src_t acc_src;
    logic     out_we;
    logic     mem_st;
    logic     prog_wr;
  } ctrl_t;

  // The instruction word must hold the opcode above the operand address.
  function automatic bit widths_ok(input int unsigned data_w, input int unsigned addr_w);
    return data_w >= addr_w + OPC_W;
  endfunction

endpackage

// File: rtl/acc_cpu_enter_sync.sv
// Operator button synchroniser with single-cycle rising-edge pulse.
module enter_sync (
  input  logic clk,
  input  logic reset,
  input  logic enter,
  output logic rise_c
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= enter;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/acc_cpu.sv
// Single-accumulator processor with unified program/data memory and a
// program-load port usable while idle or halted.
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter bit          SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              enter,
  input  logic [DATA_W-1:0] in,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out,
  output logic              halt,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] mem_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (!widths_ok(DATA_W, ADDR_W)) begin : g_bad_widths
    $error("acc_cpu: DATA_W must be at least ADDR_W+3");
  end

  state_t            state, state_nx;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [OPC_W-1:0]  ir_op;
  logic [ADDR_W-1:0] ir_a;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] out_q;
  logic              halt_q;
  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] acc_nx;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              enter_rise_c;

  enter_sync u_enter_sync (
    .clk    (clk),
    .reset  (reset),
    .enter  (enter),
    .rise_c (enter_rise_c)
  );

  assign fetch_word = mem[pc];
  assign operand    = mem[ir_a];

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; init overrides everything
  always_comb begin
    state_nx = state;
    if (init) begin
      state_nx = S_FETCH;
    end else begin
      case (state)
        S_IDLE:    state_nx = S_IDLE;
        S_FETCH:   state_nx = S_EXEC;
        S_EXEC: begin
          case (ir_op)
            OP_IN:   state_nx = S_WAIT_IN;
            OP_HALT: state_nx = S_HALT;
            default: state_nx = S_FETCH;
          endcase
        end
        S_WAIT_IN: if (enter_rise_c) state_nx = S_FETCH;
        S_HALT:    state_nx = S_HALT;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // Control decode; enter edges outside WAIT_IN fall through unused
  always_comb begin
    ctrl = '0;
    if (init) begin
      ctrl.clr = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_HALT: ctrl.prog_wr = prog_we;
        S_FETCH:        ctrl.fetch   = 1'b1;
        S_EXEC: begin
          case (ir_op)
            OP_LOAD: begin
              ctrl.acc_we  = 1'b1;
              ctrl.acc_src = ACC_MEM;
            end
            OP_STORE: ctrl.mem_st = 1'b1;
            OP_ADD: begin
              ctrl.acc_we  = 1'b1;
              ctrl.acc_src = ACC_ADD;
            end
            OP_SUB: begin
              ctrl.acc_we  = 1'b1;
              ctrl.acc_src = ACC_SUB;
            end
            OP_OUT:  ctrl.out_we = 1'b1;
            OP_JZ:   ctrl.pc_jmp = (acc == '0);
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          if (enter_rise_c) begin
            ctrl.acc_we  = 1'b1;
            ctrl.acc_src = ACC_IN;
          end
        end
        default: ;
      endcase
    end
  end

  // Extra top bit carries ADD carry-out / SUB borrow for saturation
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    acc_nx = operand;
    unique case (ctrl.acc_src)
      ACC_MEM: acc_nx = operand;
      ACC_ADD: acc_nx = (SAT && sum[DATA_W])  ? '1 : sum[DATA_W-1:0];
      ACC_SUB: acc_nx = (SAT && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
      ACC_IN:  acc_nx = in;
    endcase
  end

  // Architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      ir_op  <= '0;
      ir_a   <= '0;
      acc    <= '0;
      out_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      halt_q <= (state_nx == S_HALT);
      if (ctrl.clr) begin
        pc    <= '0;
        acc   <= '0;
        out_q <= '0;
      end else begin
        if (ctrl.fetch) begin
          ir_op <= fetch_word[DATA_W-1 -: OPC_W];
          ir_a  <= fetch_word[ADDR_W-1:0];
          pc    <= pc + ADDR_W'(1);
        end
        if (ctrl.pc_jmp) pc    <= ir_a;
        if (ctrl.acc_we) acc   <= acc_nx;
        if (ctrl.out_we) out_q <= acc;
      end
    end
  end

  // Memory has no reset so programs survive reset and init
  always_ff @(posedge clk) begin
    if (ctrl.mem_st)       mem[ir_a]      <= acc;
    else if (ctrl.prog_wr) mem[prog_addr] <= prog_data;
  end

  assign out     = out_q;
  assign halt    = halt_q;
  assign ir_addr = ir_a;
  assign pc_out  = pc;
  assign acc_out = acc;
  assign mem_out = operand;

endmodule

// File: tb/tb_acc_cpu.sv
// Checks acc_cpu in 8/5 wrap, 8/5 saturating and 12/8 configurations against
// an instruction-level reference model plus hand-computed results.
module tb_acc_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  // shared stimulus for the two 8/5 instances
  logic       init_n = 0, enter_n = 0, pwe_n = 0;
  logic [4:0] paddr_n = '0;
  logic [7:0] pdata_n = '0, in_n = '0;
  // stimulus for the 12/8 instance
  logic        init_w = 0, enter_w = 0, pwe_w = 0;
  logic [7:0]  paddr_w = '0;
  logic [11:0] pdata_w = '0, in_w = '0;

  logic [7:0]  out0, acc0, memo0, out1, acc1, memo1;
  logic [4:0]  ira0, pc0, ira1, pc1;
  logic        halt0, halt1, halt_w;
  logic [11:0] out_w, acc_w, memo_w;
  logic [7:0]  ira_w, pc_w;

  acc_cpu #(.DATA_W(8), .ADDR_W(5), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .init(init_n), .enter(enter_n), .in(in_n),
    .prog_we(pwe_n), .prog_addr(paddr_n), .prog_data(pdata_n),
    .out(out0), .halt(halt0), .ir_addr(ira0), .pc_out(pc0), .acc_out(acc0), .mem_out(memo0));

  acc_cpu #(.DATA_W(8), .ADDR_W(5), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .init(init_n), .enter(enter_n), .in(in_n),
    .prog_we(pwe_n), .prog_addr(paddr_n), .prog_data(pdata_n),
    .out(out1), .halt(halt1), .ir_addr(ira1), .pc_out(pc1), .acc_out(acc1), .mem_out(memo1));

  acc_cpu #(.DATA_W(12), .ADDR_W(8), .SAT(1'b0)) u_wide (
    .clk(clk), .reset(reset), .init(init_w), .enter(enter_w), .in(in_w),
    .prog_we(pwe_w), .prog_addr(paddr_w), .prog_data(pdata_w),
    .out(out_w), .halt(halt_w), .ir_addr(ira_w), .pc_out(pc_w), .acc_out(acc_w), .mem_out(memo_w));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_WAIT = 3, PH_HALT = 4;

  int m_ph[3], m_pc[3], m_acc[3], m_out[3], m_op[3], m_ira[3];
  bit m_e1[3], m_e2[3], m_e3[3];  // enter as seen 1, 2, 3 edges ago
  int m_mem[3][256];

  function automatic int dw(input int k);  return (k == 2) ? 12 : 8; endfunction
  function automatic int aw(input int k);  return (k == 2) ? 8 : 5;  endfunction
  function automatic bit sat(input int k); return k == 1;            endfunction

  task automatic model_reset(input int k);
    m_ph[k] = PH_IDLE; m_pc[k] = 0; m_acc[k] = 0; m_out[k] = 0; m_op[k] = 0; m_ira[k] = 0;
    m_e1[k] = 0; m_e2[k] = 0; m_e3[k] = 0;
  endtask

  task automatic model_step(input int k, input bit ini, input bit ent, input bit pwe,
                            input int pa, input int pd, input int inv);
    int mask, depth, w, opnd, r;
    bit press;
    mask  = (1 << dw(k)) - 1;
    depth = 1 << aw(k);
    press = m_e2[k] && !m_e3[k];
    m_e3[k] = m_e2[k]; m_e2[k] = m_e1[k]; m_e1[k] = ent;
    opnd = m_mem[k][m_ira[k]];
    if (ini) begin
      m_pc[k] = 0; m_acc[k] = 0; m_out[k] = 0; m_ph[k] = PH_FETCH;
    end else begin
      case (m_ph[k])
        PH_IDLE, PH_HALT: if (pwe) m_mem[k][pa] = pd;
        PH_FETCH: begin
          w = m_mem[k][m_pc[k]];
          m_op[k]  = (w >> (dw(k) - 3)) & 7;
          m_ira[k] = w % depth;
          m_pc[k]  = (m_pc[k] + 1) % depth;
          m_ph[k]  = PH_EXEC;
        end
        PH_EXEC: begin
          m_ph[k] = PH_FETCH;
          case (m_op[k])
            0: m_acc[k] = opnd;
            1: m_mem[k][m_ira[k]] = m_acc[k];
            2: begin
              r = m_acc[k] + opnd;
              if (r > mask) r = sat(k) ? mask : r - (mask + 1);
              m_acc[k] = r;
            end
            3: begin
              r = m_acc[k] - opnd;
              if (r < 0) r = sat(k) ? 0 : r + mask + 1;
              m_acc[k] = r;
            end
            4: m_ph[k] = PH_WAIT;
            5: m_out[k] = m_acc[k];
            6: if (m_acc[k] == 0) m_pc[k] = m_ira[k];
            default: m_ph[k] = PH_HALT;
          endcase
        end
        PH_WAIT: if (press) begin m_acc[k] = inv; m_ph[k] = PH_FETCH; end
        default: ;
      endcase
    end
  endtask

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int k = 0; k < 3; k++) model_reset(k);
    end else begin
      model_step(0, init_n, enter_n, pwe_n, int'(paddr_n), int'(pdata_n), int'(in_n));
      model_step(1, init_n, enter_n, pwe_n, int'(paddr_n), int'(pdata_n), int'(in_n));
      model_step(2, init_w, enter_w, pwe_w, int'(paddr_w), int'(pdata_w), int'(in_w));
    end
  end

  task automatic cmp_inst(input int k, input int pc, input int acc, input int outv,
                          input bit hl, input int ira, input int memo);
    chk($sformatf("u%0d.pc", k), pc, m_pc[k]);
    chk($sformatf("u%0d.acc", k), acc, m_acc[k]);
    chk($sformatf("u%0d.out", k), outv, m_out[k]);
    chk($sformatf("u%0d.halt", k), int'(hl), int'(m_ph[k] == PH_HALT));
    chk($sformatf("u%0d.ir_addr", k), ira, m_ira[k]);
    chk($sformatf("u%0d.mem_out", k), memo, m_mem[k][m_ira[k]]);
  endtask

  always begin
    @(negedge clk);
    if (chk_en) begin
      cmp_inst(0, int'(pc0), int'(acc0), int'(out0), halt0, int'(ira0), int'(memo0));
      cmp_inst(1, int'(pc1), int'(acc1), int'(out1), halt1, int'(ira1), int'(memo1));
      cmp_inst(2, int'(pc_w), int'(acc_w), int'(out_w), halt_w, int'(ira_w), int'(memo_w));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr_n(input int a, input int d);
    pwe_n = 1'b1; paddr_n = 5'(a); pdata_n = 8'(d); tick(1); pwe_n = 1'b0;
  endtask

  task automatic wr_w(input int a, input int d);
    pwe_w = 1'b1; paddr_w = 8'(a); pdata_w = 12'(d); tick(1); pwe_w = 1'b0;
  endtask

  task automatic init_pulse_n();
    init_n = 1'b1; tick(1); init_n = 1'b0;
  endtask

  task automatic init_pulse_w();
    init_w = 1'b1; tick(1); init_w = 1'b0;
  endtask

  task automatic wait_halt_n(input string nm, input int budget);
    int n = 0;
    while (!halt0 && n < budget) begin tick(1); n++; end
    chk(nm, int'(halt0), 1);
  endtask

  task automatic wait_halt_w(input string nm, input int budget);
    int n = 0;
    while (!halt_w && n < budget) begin tick(1); n++; end
    chk(nm, int'(halt_w), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(2);
    // reset state
    chk("rst.pc", int'(pc0), 0);   chk("rst.acc", int'(acc0), 0);
    chk("rst.out", int'(out0), 0); chk("rst.halt", int'(halt0), 0);
    chk("rst.ir_addr", int'(ira0), 0);
    chk("rst.wide_pc", int'(pc_w), 0); chk("rst.wide_halt", int'(halt_w), 0);
    reset = 1'b1;
    tick(1);

    // clear every memory word through the program port while idle
    for (int i = 0; i < 256; i++) begin
      pwe_w = 1'b1; paddr_w = 8'(i); pdata_w = '0;
      pwe_n = (i < 32); paddr_n = 5'(i); pdata_n = '0;
      tick(1);
    end
    pwe_w = 1'b0; pwe_n = 1'b0;
    chk_en = 1'b1;

    // IN 30; ADD 31; OUT 0; HALT with M[31]=5, in=7
    wr_n(0, 'h9E); wr_n(1, 'h5F); wr_n(2, 'hA0); wr_n(3, 'hE0); wr_n(31, 5);
    in_n = 8'd7;
    init_pulse_n();
    tick(3);
    enter_n = 1'b1; tick(2); enter_n = 1'b0;
    wait_halt_n("t1.halt", 30);
    chk("t1.out", int'(out0), 12); chk("t1.acc", int'(acc0), 12);
    chk("t1.sat_out", int'(out1), 12);

    // press during LOAD is discarded; held press gives a single IN
    wr_n(0, 'h1F); wr_n(1, 'h9E); wr_n(2, 'hA0); wr_n(3, 'h9E); wr_n(4, 'hA0); wr_n(5, 'hE0);
    in_n = 8'd9;
    init_pulse_n();
    enter_n = 1'b1; tick(1); enter_n = 1'b0;
    tick(8);
    chk("t2.wait_pc", int'(pc0), 2); chk("t2.wait_acc", int'(acc0), 5);
    chk("t2.wait_halt", int'(halt0), 0);
    enter_n = 1'b1; tick(10);
    chk("t2.hold_out", int'(out0), 9); chk("t2.hold_pc", int'(pc0), 4);
    chk("t2.hold_halt", int'(halt0), 0);
    enter_n = 1'b0; in_n = 8'd3; tick(3);
    enter_n = 1'b1;
    wait_halt_n("t2.halt", 20);
    enter_n = 1'b0;
    chk("t2.out", int'(out0), 3);

    // wrap vs saturate: 250+10 then 5-20
    wr_n(0, 'h1D); wr_n(1, 'h5C); wr_n(2, 'h39); wr_n(3, 'h1B);
    wr_n(4, 'h7A); wr_n(5, 'hA0); wr_n(6, 'h19); wr_n(7, 'hE0);
    wr_n(26, 20); wr_n(27, 5); wr_n(28, 10); wr_n(29, 250);
    init_pulse_n();
    wait_halt_n("t3.halt", 40);
    chk("t3.wrap_add", int'(acc0), 4);  chk("t3.wrap_sub", int'(out0), 241);
    chk("t3.sat_add", int'(acc1), 255); chk("t3.sat_sub", int'(out1), 0);

    // JZ loop: LOAD 23; OUT 0; LOAD 24; JZ 0 with M[23]=9, M[24]=0
    wr_n(0, 'h17); wr_n(1, 'hA0); wr_n(2, 'h18); wr_n(3, 'hC0); wr_n(23, 9); wr_n(24, 0);
    init_pulse_n();
    tick(12);
    chk("t4.loop_halt", int'(halt0), 0);
    wr_n(23, 'h55);
    n = 0;
    while (!(acc0 == 8'd9 && out0 == 8'd9) && n < 20) begin tick(1); n++; end
    chk("t4.seen9", int'(out0), 9);
    init_pulse_n();
    chk("t4.init_pc", int'(pc0), 0); chk("t4.init_acc", int'(acc0), 0);
    chk("t4.init_out", int'(out0), 0);
    n = 0;
    while (out0 != 8'd9 && n < 20) begin tick(1); n++; end
    chk("t4.running_write_ignored", int'(out0), 9);

    // reset mid-run
    reset = 1'b0; #1;
    chk("t5.rst_pc", int'(pc0), 0); chk("t5.rst_acc", int'(acc0), 0);
    chk("t5.rst_out", int'(out0), 0); chk("t5.rst_halt", int'(halt0), 0);
    tick(1); reset = 1'b1; tick(1);

    // write in HALT lands and is seen on re-run
    wr_n(0, 'h16); wr_n(1, 'hA0); wr_n(2, 'hE0); wr_n(22, 3);
    init_pulse_n();
    wait_halt_n("t5.halt1", 20);
    chk("t5.out1", int'(out0), 3);
    wr_n(22, 44);
    init_pulse_n();
    wait_halt_n("t5.halt2", 20);
    chk("t5.out2", int'(out0), 44);

    // 12/8: PC wraps from 255 to 0
    wr_w(0, 'hC04); wr_w(1, 'hA00); wr_w(2, 'hE00); wr_w(4, 'hCFF);
    wr_w(255, 'h0C8); wr_w(200, 'h123);
    init_pulse_w();
    wait_halt_w("t6.halt", 40);
    chk("t6.out", int'(out_w), 'h123); chk("t6.pc", int'(pc_w), 3);

    // reset while waiting for enter keeps memory
    wr_w(0, 'h0C8); wr_w(1, 'hA00); wr_w(2, 'h800);
    init_pulse_w();
    tick(8);
    chk("t6.wait_acc", int'(acc_w), 'h123); chk("t6.wait_pc", int'(pc_w), 3);
    reset = 1'b0; #1;
    chk("t6.rst_pc", int'(pc_w), 0); chk("t6.rst_acc", int'(acc_w), 0);
    chk("t6.rst_out", int'(out_w), 0); chk("t6.rst_halt", int'(halt_w), 0);
    chk("t6.rst_ir_addr", int'(ira_w), 0); chk("t6.rst_mem_out", int'(memo_w), 'h0C8);
    tick(1); reset = 1'b1; tick(1);
    init_pulse_w();
    tick(2);
    chk("t6.mem_kept", int'(acc_w), 'h123);

    tick(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
